// File: rtl/mem_bus_master_if.sv
// Core-request, response and memory-pin bundle for the RUN-mode memory initiator.
interface mem_bus_master_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic [1:0]        cpustate;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [7:0]        err_cnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cpustate, req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt,
           mem_addr, mem_read, mem_write, mem_wdata
  );

  modport slave (
    output cpustate, req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt,
           mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/mem_bus_master.sv
// CPU-side initiator: one load/store at a time to the unified program/data memory,
// with range/ROM-write checking, RUN-mode abort and a saturating error counter.
module mem_bus_master #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ROM_HI    = 5,
  parameter int unsigned RAM_DEPTH = 1024
) (
  input  logic            clk,
  input  logic            reset,
  mem_bus_master_if.master bus
);

  localparam int unsigned IDX_W = ADDR_W - ROM_HI;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [7:0]          r_err_cnt;

  logic                w_run;
  logic                w_ready;
  logic                w_accept;
  logic                w_abort;
  logic                w_mem_read;
  logic                w_mem_write;
  logic [IDX_W-1:0]    w_idx;
  logic                w_req_err;

  assign w_run     = (bus.cpustate == 2'b11);
  assign w_idx     = bus.req_addr[ADDR_W-1:ROM_HI];
  // Out-of-range index, or a store aimed at the ROM words (index 0)
  assign w_req_err = (32'(w_idx) >= RAM_DEPTH) | (bus.req_we & (w_idx == '0));
  assign w_accept  = bus.req_valid & w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = w_run & ~reset;
        if (w_accept) begin
          if (w_req_err)       w_next = S_RESP;
          else if (bus.req_we) w_next = S_WR;
          else                 w_next = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        w_mem_read = w_run;
        w_abort    = ~w_run;
        w_next     = w_run ? S_RD_WAIT : S_RESP;
      end
      S_RD_WAIT: begin
        w_mem_read = w_run;
        w_abort    = ~w_run;
        w_next     = S_RESP;
      end
      S_WR: begin
        w_mem_write = w_run;
        w_abort     = ~w_run;
        w_next      = S_RESP;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request latch, read capture and error bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_err   <= w_req_err;
        if (w_req_err) r_rdata <= '0;
      end
      if (w_abort) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
      if ((r_state == S_RD_WAIT) && w_run) begin
        r_rdata <= bus.mem_rdata;
      end
      if ((r_state == S_RESP) && r_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_err   = (r_state == S_RESP) & r_err;
  assign bus.rsp_rdata = r_rdata;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: directed timing checks plus randomized
// loads/stores checked against a byte-array reference of the memory map.
module tb_mem_bus_master;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_HI(5), .RAM_DEPTH(1024)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit         err;
    bit         chk_data;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] mem_model [int];
  logic [7:0] ref_mem   [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Power-on memory image; address 7 holds a known ROM byte
  function automatic logic [7:0] init_byte(input int a);
    if (a == 7) return 8'h3C;
    return 8'((a * 37 + 11) ^ (a >> 8));
  endfunction

  function automatic logic [7:0] model_rd(input int a);
    if (mem_model.exists(a)) return mem_model[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  // Memory with one registered read stage
  always @(posedge clk) begin
    if (bus.mem_write) mem_model[int'(bus.mem_addr)] = bus.mem_wdata;
    if (bus.mem_read)  bus.mem_rdata <= model_rd(int'(bus.mem_addr));
  end

  // Reference: classify by word index, keep a byte map of legal stores
  task automatic push_exp(input bit we, input logic [15:0] addr, input logic [7:0] wd);
    int   idx;
    exp_t e;
    idx        = int'(addr) / 32;
    e.err      = (idx >= 1024) || (we && idx == 0);
    e.chk_data = e.err || !we;
    e.rdata    = e.err ? 8'h00 : (we ? 8'h00 : ref_rd(int'(addr)));
    if (!e.err && we) ref_mem[int'(addr)] = wd;
    sb.push_back(e);
  endtask

  task automatic issue(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                       input bit abort_exp = 1'b0);
    int   n;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_chk++;
      $display("FAIL accept_timeout: req_ready stayed %0b, expected 1", bus.req_ready);
    end else if (abort_exp) begin
      e.err = 1'b1; e.chk_data = 1'b1; e.rdata = 8'h00;
      sb.push_back(e);
    end else begin
      push_exp(we, addr, wd);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'(~we);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 8'($urandom);
  endtask

  // Monitor: pops the scoreboard on each response, tracks error count and strobe rules
  int err_tot = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      err_tot = 0;
    end else begin
      chk("err_cnt", bus.err_cnt, (err_tot > 255) ? 255 : err_tot);
      chk("rw_exclusive", bus.mem_read & bus.mem_write, 0);
      if (!bus.rsp_valid) chk("rsp_err_idle", bus.rsp_err, 0);
      if (bus.mem_write) chk("write_addr_legal", (int'(bus.mem_addr) / 32 >= 1) &&
                                                 (int'(bus.mem_addr) / 32 < 1024), 1);
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with no request outstanding");
        end else begin
          e = sb.pop_front();
          chk("rsp_err", bus.rsp_err, e.err);
          if (e.chk_data) chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          if (e.err) err_tot++;
        end
      end
    end
  end

  initial begin
    int rc;
    int n;
    int cat;
    logic [15:0] a;
    bus.cpustate  = 2'b11;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    reset = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err",   bus.rsp_err,   0);
    chk("rst_err_cnt",   bus.err_cnt,   0);
    chk("rst_mem_addr",  bus.mem_addr,  0);
    chk("rst_mem_read",  bus.mem_read,  0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus.req_ready, 1);
    bus.cpustate = 2'b01;
    #1;
    chk("ready_not_run", bus.req_ready, 0);
    bus.cpustate = 2'b11;
    @(posedge clk); #1;

    // RAM store then load
    issue(1'b1, 16'h0040, 8'hA5);
    @(negedge clk);
    chk("st_mem_write", bus.mem_write, 1);
    chk("st_mem_addr",  bus.mem_addr,  16'h0040);
    chk("st_mem_wdata", bus.mem_wdata, 8'hA5);
    chk("st_mem_read",  bus.mem_read,  0);
    @(negedge clk);
    chk("st_write_once", bus.mem_write, 0);
    chk("st_rsp_valid",  bus.rsp_valid, 1);
    @(posedge clk); #1;
    issue(1'b0, 16'h0040, 8'h00);
    @(negedge clk);
    chk("ld_issue_read", bus.mem_read, 1);
    @(negedge clk);
    chk("ld_wait_read", bus.mem_read, 1);
    @(negedge clk);
    chk("ld_rsp_valid", bus.rsp_valid, 1);
    chk("ld_rsp_rdata", bus.rsp_rdata, 8'hA5);
    chk("ld_read_off",  bus.mem_read, 0);
    @(posedge clk); #1;

    // ROM load: read strobe exactly two cycles
    issue(1'b0, 16'h0007, 8'h00);
    rc = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_read) rc++;
      if (bus.rsp_valid) begin
        chk("rom_rdata", bus.rsp_rdata, 8'h3C);
        chk("rom_err",   bus.rsp_err,   0);
      end
    end
    chk("rom_read_cycles", rc, 2);
    @(posedge clk); #1;

    // ROM store and out-of-range load are errors with no strobes
    issue(1'b1, 16'h0010, 8'h5A);
    @(negedge clk);
    chk("romst_rsp_valid", bus.rsp_valid, 1);
    chk("romst_rsp_err",   bus.rsp_err,   1);
    chk("romst_rdata",     bus.rsp_rdata, 0);
    chk("romst_no_write",  bus.mem_write, 0);
    @(posedge clk); #1;
    issue(1'b0, 16'h8000, 8'h00);
    @(negedge clk);
    chk("oor_rsp_valid", bus.rsp_valid, 1);
    chk("oor_rsp_err",   bus.rsp_err,   1);
    chk("oor_rdata",     bus.rsp_rdata, 0);
    chk("oor_no_read",   bus.mem_read,  0);
    @(negedge clk);
    chk("err_cnt_two", bus.err_cnt, 2);
    @(posedge clk); #1;

    // Abort during RD_WAIT
    issue(1'b0, 16'h0041, 8'h00, 1'b1);
    @(negedge clk);
    chk("abort_issue_read", bus.mem_read, 1);
    @(posedge clk); #1;
    bus.cpustate = 2'b10;
    #1;
    chk("abort_read_drop", bus.mem_read, 0);
    @(posedge clk); #1;
    bus.cpustate = 2'b11;
    @(negedge clk);
    chk("abort_rsp_valid", bus.rsp_valid, 1);
    chk("abort_rsp_err",   bus.rsp_err,   1);
    chk("abort_rdata",     bus.rsp_rdata, 0);
    @(posedge clk); #1;

    // Error counter saturation
    repeat (300) issue(1'b1, 16'($urandom_range(0, 31)), 8'($urandom));
    repeat (2) @(negedge clk);
    chk("err_cnt_sat", bus.err_cnt, 8'hFF);
    @(posedge clk); #1;

    // Reset in the WR cycle drops the transaction
    issue(1'b1, 16'h0050, 8'h77);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_wr_cycle", bus.mem_write, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_no_write", bus.mem_write, 0);
    chk("midrst_no_rsp",   bus.rsp_valid, 0);
    chk("midrst_ready",    bus.req_ready, 1);
    @(posedge clk); #1;

    // Randomized traffic over ROM, low RAM, top RAM and out-of-range addresses
    repeat (250) begin
      cat = $urandom_range(0, 9);
      if (cat <= 2)      a = 16'($urandom_range(0, 31));
      else if (cat <= 6) a = 16'h0040 + 16'($urandom_range(0, 15));
      else if (cat <= 8) a = 16'h7FE0 + 16'($urandom_range(0, 31));
      else               a = 16'h8000 | 16'($urandom);
      issue(1'($urandom_range(0, 1)), a, 8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
